pwm_mixer_n: RTL and testbench

PWM_MIXER_N -- requirements
Module: pwm_mixer_n

---
 rtl/pwm_mixer_n_if.sv | 14 +
 rtl/pwm_mixer_n.sv | 55 +++++
 tb/tb_pwm_mixer_n.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pwm_mixer_n_if.sv
// pwm_mixer_n_if: encoder inputs and PWM/level outputs of the PWM mixer
`timescale 1ns/1ps
interface pwm_mixer_n_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8
);
  logic [CHANNELS-1:0]       enc_a;
  logic [CHANNELS-1:0]       enc_b;
  logic [CHANNELS-1:0]       pwm_out;
  logic [CHANNELS*WIDTH-1:0] level_out;
  logic                      period_start;
  modport master(output enc_a, enc_b, input pwm_out, level_out, period_start);
  modport slave(input enc_a, enc_b, output pwm_out, level_out, period_start);
endinterface

// File: rtl/pwm_mixer_n.sv
// pwm_mixer_n: debounced quadrature encoders driving per-channel levels and shadowed PWM outputs
`timescale 1ns/1ps
module pwm_mixer_n #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int HIST_LEN = 8,
  parameter int SATURATE = 1,
  parameter int STEP     = 1
) (
  input logic clk,
  input logic reset_n,
  pwm_mixer_n_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  logic [WIDTH-1:0] cnt;
  // shared free-running period counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= cnt + 1'b1;
  assign bus.period_start = cnt == '0;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [HIST_LEN-1:0] hist_a, hist_b, ha_n, hb_n;
    logic                deb_a, deb_b, a_q;
    logic [WIDTH-1:0]    level, duty, up_v, dn_v;
    logic [WIDTH:0]      sum, diff;
    assign ha_n = {hist_a[HIST_LEN-2:0], bus.enc_a[i]};
    assign hb_n = {hist_b[HIST_LEN-2:0], bus.enc_b[i]};
    assign sum  = {1'b0, level} + STEP_W;
    assign diff = {1'b0, level} - STEP_W;
    assign up_v = (SATURATE != 0 && sum[WIDTH]) ? MAX : sum[WIDTH-1:0];
    assign dn_v = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
    // debounce, detent decode, level update and duty shadow load at period wrap
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        hist_a <= '0;
        hist_b <= '0;
        deb_a  <= 1'b0;
        deb_b  <= 1'b0;
        a_q    <= 1'b0;
        level  <= '0;
        duty   <= '0;
      end else begin
        hist_a <= ha_n;
        hist_b <= hb_n;
        deb_a  <= &ha_n ? 1'b1 : (~|ha_n ? 1'b0 : deb_a);
        deb_b  <= &hb_n ? 1'b1 : (~|hb_n ? 1'b0 : deb_b);
        a_q    <= deb_a;
        if (deb_a && !a_q) level <= deb_b ? dn_v : up_v;
        if (cnt == MAX) duty <= level;
      end
    assign bus.pwm_out[i]                 = cnt < duty;
    assign bus.level_out[i*WIDTH +: WIDTH] = level;
  end
endmodule

// File: tb/tb_pwm_mixer_n.sv
// tb_pwm_mixer_n: randomized detent stimulus checked against a cycle-level arithmetic model
`timescale 1ns/100ps
module tb_pwm_mixer_n;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] enc_a = '0, enc_b = '0;
  int n_chk = 0, n_err = 0;
  int sat_p[3]  = '{1, 0, 0};
  int step_p[3] = '{1, 1, 16};
  int lvl[3][3], duty[3][3];
  int cnt = 0;
  bit [2:0] msk, dir;
  always #5 clk = ~clk;
  pwm_mixer_n_if #(.CHANNELS(3), .WIDTH(8)) if0();
  pwm_mixer_n_if #(.CHANNELS(3), .WIDTH(8)) if1();
  pwm_mixer_n_if #(.CHANNELS(3), .WIDTH(8)) if2();
  assign if0.enc_a = enc_a;
  assign if0.enc_b = enc_b;
  assign if1.enc_a = enc_a;
  assign if1.enc_b = enc_b;
  assign if2.enc_a = enc_a;
  assign if2.enc_b = enc_b;
  pwm_mixer_n #(.SATURATE(1), .STEP(1))  u0(.clk(clk), .reset_n(reset_n), .bus(if0));
  pwm_mixer_n #(.SATURATE(0), .STEP(1))  u1(.clk(clk), .reset_n(reset_n), .bus(if1));
  pwm_mixer_n #(.SATURATE(0), .STEP(16)) u2(.clk(clk), .reset_n(reset_n), .bus(if2));
  logic [2:0]  pwm_g[3];
  logic [23:0] lvl_g[3];
  logic        ps_g[3];
  assign pwm_g[0] = if0.pwm_out;
  assign pwm_g[1] = if1.pwm_out;
  assign pwm_g[2] = if2.pwm_out;
  assign lvl_g[0] = if0.level_out;
  assign lvl_g[1] = if1.level_out;
  assign lvl_g[2] = if2.level_out;
  assign ps_g[0]  = if0.period_start;
  assign ps_g[1]  = if1.period_start;
  assign ps_g[2]  = if2.period_start;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int nxt(int l, bit dn, int sat, int st);
    int v = dn ? l - st : l + st;
    if (sat != 0) return v > 255 ? 255 : (v < 0 ? 0 : v);
    return ((v % 256) + 256) % 256;
  endfunction
  task automatic clear_model();
    cnt = 0;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 3; c++) begin
        lvl[k][c]  = 0;
        duty[k][c] = 0;
      end
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [23:0] el;
      logic [2:0]  ep;
      for (int c = 0; c < 3; c++) begin
        el[c*8 +: 8] = 8'(lvl[k][c]);
        ep[c]        = cnt < duty[k][c];
      end
      chk($sformatf("level%0d", k), lvl_g[k], el);
      chk($sformatf("pwm%0d", k), pwm_g[k], ep);
      chk($sformatf("period_start%0d", k), ps_g[k], cnt == 0);
    end
  endtask
  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_level"}, lvl_g[k], 0);
      chk({tag, "_pwm"}, pwm_g[k], 0);
      chk({tag, "_ps"}, ps_g[k], 1);
    end
  endtask
  task automatic tick(input bit apply);
    int old[3][3];
    old = lvl;
    @(posedge clk);
    if (apply)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 3; c++)
          if (msk[c]) lvl[k][c] = nxt(lvl[k][c], dir[c], sat_p[k], step_p[k]);
    cnt = (cnt + 1) % 256;
    if (cnt == 0) duty = old;
    #1;
    check_all();
  endtask
  task automatic detent(input bit [2:0] mask, input bit [2:0] dn);
    enc_b = (enc_b & ~mask) | (dn & mask);
    enc_a = mask;
    repeat (8) tick(0);
    msk = mask;
    dir = dn;
    tick(1);
    enc_a = '0;
    repeat (9) tick(0);
  endtask
  task automatic wait_cnt(input int target);
    while (cnt != target) tick(0);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end
  initial begin
    clear_model();
    repeat (5) begin
      @(posedge clk);
      enc_a = 3'($urandom);
      enc_b = 3'($urandom);
      #1;
      check_reset_state("reset");
    end
    enc_a = '0;
    enc_b = '0;
    reset_n = 1'b1;
    check_all();
    detent(3'b001, 3'b000);
    repeat (300) tick(0);
    enc_a[1] = 1'b1;
    repeat (7) tick(0);
    enc_a[1] = 1'b0;
    repeat (9) tick(0);
    for (int i = 0; i < 20; i++) begin
      enc_b[1] = ~enc_b[1];
      repeat (i % 10 + 1) tick(0);
    end
    enc_b[1] = 1'b0;
    repeat (10) tick(0);
    detent(3'b100, 3'b100);
    detent(3'b100, 3'b000);
    repeat (300) detent(3'b001, 3'b000);
    repeat (260) detent(3'b001, 3'b001);
    detent(3'b010, 3'b010);
    detent(3'b010, 3'b000);
    wait_cnt(91);
    detent(3'b001, 3'b000);
    repeat (300) tick(0);
    detent(3'b111, 3'($urandom));
    repeat (300) tick(0);
    for (int i = 0; i < 40; i++) detent(3'($urandom_range(1, 7)), 3'($urandom));
    repeat (300) tick(0);
    detent(3'b111, 3'b000);
    wait_cnt(57);
    reset_n = 1'b0;
    #0.5;
    check_reset_state("midreset");
    #0.5;
    reset_n = 1'b1;
    clear_model();
    check_all();
    repeat (300) tick(0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
